// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer.
// Contents:
//   btn_state_t      per-button debounce FSM encoding
//   CNT_MAX_DEFAULT  default number of agreeing cycles needed to accept a new level
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'b00,
    ARM_HI   = 2'b01,
    PRESSED  = 2'b10,
    ARM_LO   = 2'b11
  } btn_state_t;

  // 10 ms at 100 MHz
  localparam int CNT_MAX_DEFAULT = 1000000;

endpackage

// File: rtl/btn_debounce_bit.sv
// Debounce for a single push button: 2-FF synchroniser, stability FSM with
// counter, registered debounced level and a one-cycle press strobe.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high reset
//   btn    raw asynchronous button level
//   pulse  one-cycle strobe on the first cycle level is 1
//   level  debounced button level
//
// state    | meaning
// RELEASED | level 0, input agrees
// ARM_HI   | level 0, input high, counting toward acceptance
// PRESSED  | level 1, input agrees
// ARM_LO   | level 1, input low, counting toward acceptance
module btn_debounce_bit
  import btn_pkg::*;
#(
  parameter int NB_CNT  = 20,
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse,
  output logic level
);

  localparam logic [NB_CNT-1:0] CNT_TOP = NB_CNT'(CNT_MAX);
  localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);

  logic              meta;
  logic              sync;
  btn_state_t        state_q, state_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic              pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync) begin
          state_d = ARM_HI;
          cnt_d   = CNT_ONE;
        end
      end
      ARM_HI: begin
        if (!sync) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TOP) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_d = ARM_LO;
          cnt_d   = CNT_ONE;
        end
      end
      ARM_LO: begin
        if (sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TOP) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      meta    <= btn;
      sync    <= meta;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Level is the MSB of the state encoding: 1 in PRESSED and ARM_LO.
  assign level = state_q[1];
  assign pulse = pulse_q;

endmodule

// File: rtl/btn_debouncer.sv
// Debounces the operand/opcode load buttons and emits one load strobe per
// physical press.
// Optional feature macro: BTN_ONEHOT_PRIORITY_EN -- when defined, coincident
// strobes are reduced to the lowest-index one so the load decoder only ever
// sees one-hot strobes.
// Ports:
//   clock        system clock
//   i_reset      synchronous, active-high reset
//   i_btn        raw asynchronous button levels
//   o_btn_pulse  one-cycle strobe per accepted press
//   o_btn_level  debounced button levels
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int NB_BTN  = 3,
  parameter int NB_CNT  = 20,
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_pulse,
  output logic [NB_BTN-1:0] o_btn_level
);

  logic [NB_BTN-1:0] pulse_raw;

  for (genvar k = 0; k < NB_BTN; k++) begin : g_btn
    btn_debounce_bit #(
      .NB_CNT  (NB_CNT),
      .CNT_MAX (CNT_MAX)
    ) u_bit (
      .clock (clock),
      .reset (i_reset),
      .btn   (i_btn[k]),
      .pulse (pulse_raw[k]),
      .level (o_btn_level[k])
    );
  end

`ifdef BTN_ONEHOT_PRIORITY_EN
  // x & -x isolates the lowest set bit.
  assign o_btn_pulse = pulse_raw & (~pulse_raw + NB_BTN'(1));
`else
  assign o_btn_pulse = pulse_raw;
`endif

endmodule

// File: tb/tb_btn_debouncer.sv
module tb_btn_debouncer;

  localparam int NB_BTN  = 3;
  localparam int NB_CNT  = 3;
  localparam int CNT_MAX = 4;
  // Input driven on a negedge is captured on the next posedge; the output
  // changes 2+CNT_MAX edges after that, i.e. visible CNT_MAX+3 negedges later.
  localparam int LAT = CNT_MAX + 3;

`ifdef BTN_ONEHOT_PRIORITY_EN
  localparam logic [2:0] EXP_DUAL = 3'b001;
`else
  localparam logic [2:0] EXP_DUAL = 3'b101;
`endif

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } exp_t;

  logic              clock = 1'b0;
  logic              i_reset = 1'b1;
  logic [NB_BTN-1:0] i_btn = '0;
  logic [NB_BTN-1:0] o_btn_pulse;
  logic [NB_BTN-1:0] o_btn_level;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  btn_debouncer #(
    .NB_BTN  (NB_BTN),
    .NB_CNT  (NB_CNT),
    .CNT_MAX (CNT_MAX)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_btn       (i_btn),
    .o_btn_pulse (o_btn_pulse),
    .o_btn_level (o_btn_level)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Scoreboard: every nonzero strobe must match the next expected entry.
  always @(negedge clock) begin
    if (mon_en && o_btn_pulse !== 3'b000) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, o_btn_pulse);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || mon_e.val !== o_btn_pulse) begin
          miscompares++;
          $display("FAIL pulse cyc=%0d got=%b required cyc=%0d val=%b",
                   cyc, o_btn_pulse, mon_e.cyc, mon_e.val);
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clock);
    i_reset = 1'b1;
    i_btn   = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      mon_en = 1'b1;
      vectors++;
      if (o_btn_pulse !== 3'b000 || o_btn_level !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_state got pulse=%b level=%b required 000/000", o_btn_pulse, o_btn_level);
      end
    end
    i_reset = 1'b0;
    i_btn   = 3'b000;
    repeat (LAT + 2) @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b000) begin
      miscompares++;
      $display("FAIL post_reset_level got=%b required=000", o_btn_level);
    end
  endtask

  task automatic test_single_press();
    i_btn[0] = 1'b1;
    sb.push_back('{cyc + LAT, 3'b001});
    repeat (LAT - 1) @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b000) begin
      miscompares++;
      $display("FAIL press_early got=%b required=000", o_btn_level);
    end
    @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b001) begin
      miscompares++;
      $display("FAIL press_level got=%b required=001", o_btn_level);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      vectors++;
      if (o_btn_level !== 3'b001 || o_btn_pulse !== 3'b000) begin
        miscompares++;
        $display("FAIL press_hold got level=%b pulse=%b required 001/000", o_btn_level, o_btn_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [8];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      i_btn[1] = pat[i];
      if (i == 7) sb.push_back('{cyc + LAT, 3'b010});
      @(negedge clock);
    end
    vectors++;
    if (o_btn_level !== 3'b001) begin
      miscompares++;
      $display("FAIL bounce_level_early got=%b required=001", o_btn_level);
    end
    repeat (LAT - 1) @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b011) begin
      miscompares++;
      $display("FAIL bounce_level got=%b required=011", o_btn_level);
    end
  endtask

  task automatic test_release();
    i_btn[0] = 1'b0;
    repeat (LAT - 1) @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b011) begin
      miscompares++;
      $display("FAIL release_early got=%b required=011", o_btn_level);
    end
    @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b010) begin
      miscompares++;
      $display("FAIL release_level got=%b required=010", o_btn_level);
    end
    i_btn[1] = 1'b0;
    repeat (LAT + 2) @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b000) begin
      miscompares++;
      $display("FAIL release_all got=%b required=000", o_btn_level);
    end
  endtask

  task automatic test_simultaneous();
    i_btn = 3'b101;
    sb.push_back('{cyc + LAT, EXP_DUAL});
    repeat (LAT) @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b101) begin
      miscompares++;
      $display("FAIL dual_level got=%b required=101", o_btn_level);
    end
    i_btn = 3'b000;
    repeat (LAT + 2) @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b000) begin
      miscompares++;
      $display("FAIL dual_release got=%b required=000", o_btn_level);
    end
  endtask

  task automatic test_reset_mid_count();
    i_btn = 3'b100;
    repeat (3) @(negedge clock);
    i_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (o_btn_pulse !== 3'b000 || o_btn_level !== 3'b000) begin
        miscompares++;
        $display("FAIL midreset_state got pulse=%b level=%b required 000/000", o_btn_pulse, o_btn_level);
      end
    end
    i_reset = 1'b0;
    sb.push_back('{cyc + LAT, 3'b100});
    repeat (LAT - 1) @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b000) begin
      miscompares++;
      $display("FAIL midreset_early got=%b required=000", o_btn_level);
    end
    @(negedge clock);
    vectors++;
    if (o_btn_level !== 3'b100) begin
      miscompares++;
      $display("FAIL midreset_level got=%b required=100", o_btn_level);
    end
    i_btn = 3'b000;
    repeat (LAT + 2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_count();
    repeat (5) @(negedge clock);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_pulses got=%0d outstanding required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
Upstream conditioning stage for the operand/opcode load buttons.
- Synchronises raw asynchronous push-button inputs into the clock domain.
- Filters contact bounce with a per-button stability counter.
- Emits one-cycle load strobes, so each physical press loads the A, B or opcode register exactly once.
- Output o_btn_pulse drives the button input of the operand-load/ALU top level directly.

Parameters:
NB_BTN, 3, number of buttons (one strobe per button)
NB_CNT, 20, width of each stability counter
CNT_MAX, 1000000, consecutive agreeing cycles needed to accept a new level (10 ms at 100 MHz); range 1..2^NB_CNT-1

Ports:
clock  input  1  system clock
i_reset  input  1  synchronous, active-high reset
i_btn  input  NB_BTN  raw button levels, asynchronous, active-high
o_btn_pulse  output  NB_BTN  one-cycle strobe per accepted press
o_btn_level  output  NB_BTN  debounced button level

Behaviour:
- Clock and reset: one clock, `clock`; reset `i_reset` is synchronous and active-high.
- Reset state: synchroniser flops, counters, debounced levels and strobes are all 0, so o_btn_pulse = 0 and o_btn_level = 0. Reset overrides all other activity in the same cycle.
- Synchroniser: 2-FF chain per bit. The sync value lags i_btn by 2 clocks.
- Per-bit FSM, counter cnt of NB_CNT bits:
  - RELEASED (level 0): sync=1 -> ARM_HI, cnt=1.
  - ARM_HI: sync=0 -> RELEASED, cnt=0. sync=1 and cnt==CNT_MAX -> PRESSED, cnt=0. Otherwise cnt+1.
  - PRESSED (level 1): sync=0 -> ARM_LO, cnt=1.
  - ARM_LO: sync=1 -> PRESSED, cnt=0. sync=0 and cnt==CNT_MAX -> RELEASED, cnt=0. Otherwise cnt+1.
- Counter range: cnt never exceeds CNT_MAX, so no wrap-around.
- Level latency: o_btn_level changes exactly 2+CNT_MAX clocks after a clean i_btn edge.
- Any disagreeing sample restarts the count. Glitches shorter than CNT_MAX cycles produce no output change.
- o_btn_level is registered and equals 1 in PRESSED and ARM_LO.
- o_btn_pulse[k]: registered and high for exactly 1 cycle, the first cycle o_btn_level[k] is 1 (ARM_HI -> PRESSED transition). Release produces no pulse.
- Holding a button produces no further pulses; there is no auto-repeat.
- Buttons are independent. Simultaneous presses may pulse in the same cycle (see optional feature).
- Reset mid-count: the count is discarded. A button still held after reset release is a new press and pulses 2+CNT_MAX cycles after reset deasserts.

Optional Feature:
Macro BTN_ONEHOT_PRIORITY_EN.
- Defined: if more than one pulse would assert in the same cycle, only the lowest-index one is output and the others are dropped. The downstream load decoder sees one-hot strobes only. o_btn_level is unaffected.
- Undefined: pulses pass through unmasked, and multi-hot strobes are possible.

Decomposition:
- Package btn_pkg:
  - FSM state encoding constants: RELEASED=2'b00, ARM_HI=2'b01, PRESSED=2'b10, ARM_LO=2'b11.
  - Default CNT_MAX constant.
- Sub-module btn_debounce_bit:
  - Contents: synchroniser, FSM, counter, level and pulse for one button.
  - Instantiated NB_BTN times in a generate loop.
  - Top level holds only the instantiations and the optional priority mask.

Test Plan (CNT_MAX=4, NB_CNT=3):
1. Assert i_reset 3 cycles with i_btn=3'b111 -> o_btn_pulse=0 and o_btn_level=0 throughout reset.
2. i_btn[0] 0->1, held 20 cycles -> o_btn_level[0] rises 6 cycles after the edge. o_btn_pulse=3'b001 for exactly that one cycle, then 0 while held.
3. i_btn[1] pattern 1,1,1,0,1,1,0 then held 1 -> no pulse during the bounce. A single pulse 3'b010 occurs 6 cycles after the final rising edge.
4. Release i_btn[0] after step 2 -> o_btn_level[0] falls 6 cycles later. o_btn_pulse stays 0.
5. i_btn 000->101 in the same cycle -> without macro, o_btn_pulse=3'b101 for one cycle. With BTN_ONEHOT_PRIORITY_EN, o_btn_pulse=3'b001 and o_btn_level=3'b101.
6. Press i_btn[2], assert i_reset 3 cycles into the count while still holding -> no pulse during reset. Pulse 3'b100 occurs 6 cycles after i_reset deasserts.
